// File: rtl/alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : alu_seq                                                     |
// | Description: Handshaked ALU; single-cycle logic/arith ops, optional      |
// |              WIDTH-cycle shift-add multiply enabled by ALU_SEQ_MUL_EN.    |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module alu_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic             Z,
    output logic             C,
    output logic             V
);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_NOR = 4'b1100;
    localparam logic [3:0] c_OP_SLT = 4'b0111;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_DONE = 2'd2;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] c_OP_MUL = 4'b1000;
    localparam logic [1:0] c_BUSY   = 2'd1;
    localparam int         c_CW     = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
`endif

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_r;
    logic             r_z;
    logic             r_c;
    logic             r_v;

    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_z;
    logic             w_accept;
    logic             w_alu_load;

    assign w_accept = in_valid && (r_state == c_IDLE);

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] r_ma;
    logic [WIDTH-1:0] r_mb;
    logic [WIDTH-1:0] r_acc;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_is_mul;
    logic             w_mul_start;
    logic             w_mul_last;

    assign w_is_mul    = (ALUOp == c_OP_MUL);
    assign w_mul_start = w_accept && w_is_mul;
    assign w_alu_load  = w_accept && !w_is_mul;
    assign w_mul_last  = (r_state == c_BUSY) && (r_cnt == c_LAST);
    assign w_acc_next  = r_acc + (r_mb[0] ? r_ma : '0);

    // Multiplicand shifts left, multiplier shifts right; bits past WIDTH fall off.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ma  <= '0;
            r_mb  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_mul_start) begin
            r_ma  <= A;
            r_mb  <= B;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == c_BUSY) begin
            r_ma  <= r_ma << 1;
            r_mb  <= r_mb >> 1;
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + c_CW'(1);
        end
    end
`else
    assign w_alu_load = w_accept;
`endif

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (ALUOp)
            c_OP_AND: w_res = A & B;
            c_OP_OR:  w_res = A | B;
            c_OP_NOR: w_res = ~(A | B);
            c_OP_ADD: begin
                {w_c, w_res} = {1'b0, A} + {1'b0, B};
                w_v = (A[WIDTH-1] == B[WIDTH-1]) && (w_res[WIDTH-1] != A[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res = A - B;
                w_c   = (A >= B);
                w_v   = (A[WIDTH-1] != B[WIDTH-1]) && (w_res[WIDTH-1] != A[WIDTH-1]);
            end
            c_OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default:  w_res = '0;
        endcase
    end

    assign w_z = (w_res == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    w_state_next = w_is_mul ? c_BUSY : c_DONE;
`else
                    w_state_next = c_DONE;
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            c_BUSY: begin
                if (r_cnt == c_LAST) begin
                    w_state_next = c_DONE;
                end
            end
`endif
            c_DONE: begin
                if (out_ready) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_IDLE);
        out_valid = (r_state == c_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_r <= '0;
            r_z <= 1'b0;
            r_c <= 1'b0;
            r_v <= 1'b0;
        end else if (w_alu_load) begin
            r_r <= w_res;
            r_z <= w_z;
            r_c <= w_c;
            r_v <= w_v;
        end
`ifdef ALU_SEQ_MUL_EN
        else if (w_mul_last) begin
            r_r <= w_acc_next;
            r_z <= (w_acc_next == '0);
            r_c <= 1'b0;
            r_v <= 1'b0;
        end
`endif
    end

    assign R = r_r;
    assign Z = r_z;
    assign C = r_c;
    assign V = r_v;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_alu_seq                                                  |
// | Description: Directed self-checking bench for alu_seq (WIDTH=64).        |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_alu_seq;

    localparam int W = 64;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   ALUOp;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] R;
    logic         Z;
    logic         C;
    logic         V;

    int n_tests;
    int n_fail;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ALUOp     (ALUOp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R),
        .Z         (Z),
        .C         (C),
        .V         (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Present one transfer for exactly one edge; caller sits #1 after an edge.
    task automatic accept(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        ALUOp    = op;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A        = '1;
        B        = '1;
        ALUOp    = 4'b0010;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({out_valid, R, Z, C, V} !== {1'b0, {W{1'b0}}, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%0b R=%h ZCV=%b%b%b want v=0 R=0 ZCV=000", out_valid, R, Z, C, V);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got %0b want 1", in_ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_add_carry();
        accept(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        n_tests++;
        if ({out_valid, R, Z, C, V} !== {1'b1, 64'h0, 3'b110}) begin
            n_fail++;
            $display("FAIL add_carry got v=%0b R=%h ZCV=%b%b%b want v=1 R=0 ZCV=110", out_valid, R, Z, C, V);
        end
        release_out();
    endtask

    task automatic test_sub_overflow();
        accept(4'b0110, 64'h8000_0000_0000_0000, 64'h1);
        n_tests++;
        if ({out_valid, R, Z, C, V} !== {1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b011}) begin
            n_fail++;
            $display("FAIL sub_overflow got v=%0b R=%h ZCV=%b%b%b want v=1 R=7fffffffffffffff ZCV=011", out_valid, R, Z, C, V);
        end
        release_out();
    endtask

    task automatic test_ops();
        logic [3:0]   op [10];
        logic [W-1:0] a  [10];
        logic [W-1:0] b  [10];
        logic [W-1:0] er [10];
        logic [2:0]   ef [10];
        op[0] = 4'b0000; a[0] = 64'hF0;                  b[0] = 64'h0F; er[0] = 64'h0;                   ef[0] = 3'b100;
        op[1] = 4'b0001; a[1] = 64'hF0;                  b[1] = 64'h0F; er[1] = 64'hFF;                  ef[1] = 3'b000;
        op[2] = 4'b1100; a[2] = 64'h0;                   b[2] = 64'h0;  er[2] = 64'hFFFF_FFFF_FFFF_FFFF; ef[2] = 3'b000;
        op[3] = 4'b0111; a[3] = 64'hFFFF_FFFF_FFFF_FFFF; b[3] = 64'h1;  er[3] = 64'h1;                   ef[3] = 3'b000;
        op[4] = 4'b0111; a[4] = 64'h1;  b[4] = 64'hFFFF_FFFF_FFFF_FFFF; er[4] = 64'h0;                   ef[4] = 3'b100;
        op[5] = 4'b0110; a[5] = 64'h1;                   b[5] = 64'h2;  er[5] = 64'hFFFF_FFFF_FFFF_FFFF; ef[5] = 3'b000;
        op[6] = 4'b0010; a[6] = 64'h7FFF_FFFF_FFFF_FFFF; b[6] = 64'h1;  er[6] = 64'h8000_0000_0000_0000; ef[6] = 3'b001;
        op[7] = 4'b0110; a[7] = 64'h5;                   b[7] = 64'h5;  er[7] = 64'h0;                   ef[7] = 3'b110;
        op[8] = 4'b1111; a[8] = 64'hF;                   b[8] = 64'hF;  er[8] = 64'h0;                   ef[8] = 3'b100;
        op[9] = 4'b0010; a[9] = 64'h8000_0000_0000_0000; b[9] = 64'h8000_0000_0000_0000;
        er[9] = 64'h0; ef[9] = 3'b111;
        for (int i = 0; i < 10; i++) begin
            accept(op[i], a[i], b[i]);
            n_tests++;
            if ({out_valid, R, Z, C, V} !== {1'b1, er[i], ef[i]}) begin
                n_fail++;
                $display("FAIL op_%0d(%b) got v=%0b R=%h ZCV=%b%b%b want v=1 R=%h ZCV=%b",
                         i, op[i], out_valid, R, Z, C, V, er[i], ef[i]);
            end
            release_out();
            n_tests++;
            if ({in_ready, out_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL op_%0d_release got rdy=%0b v=%0b want rdy=1 v=0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_stall();
        int bad;
        bad = 0;
        accept(4'b0000, 64'hF0, 64'h0F);
        ALUOp    = 4'b0001;
        A        = 64'h1234;
        B        = 64'h5678;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if ({out_valid, R, Z, in_ready} !== {1'b1, 64'h0, 1'b1, 1'b0}) bad++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_tests++;
        if (bad != 0 || {out_valid, R, Z, in_ready} !== {1'b1, 64'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_hold got %0d bad cycles, now v=%0b R=%h Z=%0b rdy=%0b want v=1 R=0 Z=1 rdy=0",
                     bad, out_valid, R, Z, in_ready);
        end
        release_out();
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_release got rdy=%0b v=%0b want rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_mul();
        int edges;
        int busy_bad;
`ifdef ALU_SEQ_MUL_EN
        logic [W-1:0] exp_r [2];
        logic [W-1:0] ma    [2];
        logic [W-1:0] mb    [2];
        ma[0] = 64'h3;                   mb[0] = 64'h5; exp_r[0] = 64'hF;
        ma[1] = 64'hFFFF_FFFF_FFFF_FFFF; mb[1] = 64'h2; exp_r[1] = 64'hFFFF_FFFF_FFFF_FFFE;
        for (int k = 0; k < 2; k++) begin
            accept(4'b1000, ma[k], mb[k]);
            edges    = 1;
            busy_bad = 0;
            while (!out_valid && edges < 200) begin
                if (in_ready !== 1'b0) busy_bad++;
                @(posedge clk);
                #1;
                edges++;
            end
            n_tests++;
            if (edges != W + 1 || busy_bad != 0) begin
                n_fail++;
                $display("FAIL mul_%0d_latency got %0d edges (%0d ready cycles) want %0d edges (0)",
                         k, edges, busy_bad, W + 1);
            end
            n_tests++;
            if ({out_valid, R, Z, C, V} !== {1'b1, exp_r[k], 3'b000}) begin
                n_fail++;
                $display("FAIL mul_%0d_result got v=%0b R=%h ZCV=%b%b%b want v=1 R=%h ZCV=000",
                         k, out_valid, R, Z, C, V, exp_r[k]);
            end
            release_out();
        end
`else
        edges    = 0;
        busy_bad = 0;
        accept(4'b1000, 64'h3, 64'h5);
        n_tests++;
        if ({out_valid, R, Z, C, V, edges, busy_bad} !== {1'b1, 64'h0, 3'b100, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL mul_disabled got v=%0b R=%h ZCV=%b%b%b want v=1 R=0 ZCV=100", out_valid, R, Z, C, V);
        end
        release_out();
`endif
    endtask

    task automatic test_reset_mid_mul();
        accept(4'b1000, 64'h3, 64'h5);
        repeat (18) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_tests++;
        if ({out_valid, R, in_ready} !== {1'b0, 64'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid_mul got v=%0b R=%h rdy=%0b want v=0 R=0 rdy=1", out_valid, R, in_ready);
        end
        accept(4'b0010, 64'h2, 64'h2);
        n_tests++;
        if ({out_valid, R, Z, C, V} !== {1'b1, 64'h4, 3'b000}) begin
            n_fail++;
            $display("FAIL after_reset_add got v=%0b R=%h ZCV=%b%b%b want v=1 R=4 ZCV=000", out_valid, R, Z, C, V);
        end
        release_out();
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        ALUOp     = 4'b0000;
        test_reset();
        test_add_carry();
        test_sub_overflow();
        test_ops();
        test_stall();
        test_mul();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
